// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Holds the clock low to inhibit the bus and drives the start bit. It then
// shifts out 8 data bits LSB first, an odd-parity bit and the stop bit, one
// per device clock falling edge. After that it samples the device ACK and
// waits for both lines to return high. A watchdog aborts the transfer if the
// device stalls after the clock is released.
// The *_oe outputs are open-drain enables: 1 pulls the line low.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] data,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   // Last inhibit cycle, and the one before it (start bit goes out on the last one).
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   // Counter value in the cycle before the timeout pulse becomes visible,
   // so the pulse lands exactly TIMEOUT_CYCLES cycles after TX entry.
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_TX,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic             clk_meta_q, clk_sync_q, clk_prev_q;
   logic             dat_meta_q, dat_sync_q;
   logic [7:0]       data_q, data_d;
   logic             parity_q, parity_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic             timeout_q, timeout_d;
   logic             fall;
   logic             to_hit;

   assign fall   = clk_prev_q & ~clk_sync_q;
   assign to_hit = (to_cnt_q == TO_LAST);

   // Next-state and next-output computation for the transmit sequencer.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      parity_d  = parity_q;
      inh_cnt_d = inh_cnt_q;
      to_cnt_d  = to_cnt_q;
      bit_cnt_d = bit_cnt_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      busy_d    = busy_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            if (send) begin
               data_d    = data;
               parity_d  = ~^data;
               state_d   = S_INHIBIT;
               clk_oe_d  = 1'b1;
               dat_oe_d  = (INHIBIT_CYCLES == 1);
               busy_d    = 1'b1;
               ack_err_d = 1'b0;
               inh_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end
         S_INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               state_d  = S_TX;
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               to_cnt_d = '0;
            end else begin
               inh_cnt_d = inh_cnt_q + INH_W'(1);
               if (inh_cnt_q == INH_PRE) begin
                  dat_oe_d = 1'b1;
               end
            end
         end
         S_TX, S_ACK, S_WAIT_IDLE: begin
            // The watchdog wins over any edge that lands in the same cycle.
            if (to_hit) begin
               state_d   = S_IDLE;
               clk_oe_d  = 1'b0;
               dat_oe_d  = 1'b0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (state_q == S_TX) begin
                  if (fall) begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                     if (bit_cnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                     end else if (bit_cnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                     end else begin
                        dat_oe_d = 1'b0;
                        state_d  = S_ACK;
                     end
                  end
               end else if (state_q == S_ACK) begin
                  if (fall) begin
                     ack_err_d = dat_sync_q;
                     state_d   = S_WAIT_IDLE;
                  end
               end else begin
                  if (clk_sync_q && dat_sync_q) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d  = S_IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State, counters, synchronisers and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         data_q     <= '0;
         parity_q   <= 1'b0;
         inh_cnt_q  <= '0;
         to_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_meta_q <= ps2_clk_in;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat_in;
         dat_sync_q <= dat_meta_q;
         data_q     <= data_d;
         parity_q   <= parity_d;
         inh_cnt_q  <= inh_cnt_d;
         to_cnt_q   <= to_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
         timeout_q  <= timeout_d;
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ack_err    = ack_err_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames and captures the line
// levels, and a scoreboard monitor checks each done/timeout pulse against the
// expected result that the stimulus queued.
module tb_ps2_host_tx;

   localparam int INH = 16;
   localparam int TO  = 200;
   localparam int H   = 6;   // device clock half period, in system cycles

   logic       clock = 1'b0;
   logic       reset;
   logic       send;
   logic [7:0] data;
   logic       dev_clk, dev_dat;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout;

   // Open-drain bus: a line is low if either side pulls it low.
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .send       (send),
      .data       (data),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .ack_err    (ack_err),
      .timeout    (timeout)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      bit         is_to;
      logic [10:0] bits;   // line levels: [0]=start, [8:1]=data, [9]=parity, [10]=stop
      bit         ack_err;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [10:0] cap_bits = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic push_exp(input bit is_to, input logic [10:0] bits, input bit ae);
      exp_t e;
      e.is_to   = is_to;
      e.bits    = bits;
      e.ack_err = ae;
      exp_q.push_back(e);
   endtask

   // Monitor: measures inhibit length and TX entry time, and scores every
   // done/timeout pulse against the head of the expectation queue.
   logic clk_oe_prev  = 1'b0;
   int   inh_run      = 0;
   int   inh_len_last = 0;
   int   tx_entry_cyc = 0;
   always @(negedge clock) begin
      exp_t e;
      if (ps2_clk_oe && !clk_oe_prev) inh_run = 1;
      else if (ps2_clk_oe) inh_run++;
      if (!ps2_clk_oe && clk_oe_prev) begin
         inh_len_last = inh_run;
         tx_entry_cyc = cyc;
      end
      clk_oe_prev = ps2_clk_oe;
      if (done || timeout) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got done=%0b timeout=%0b, expected none", done, timeout);
         end else begin
            e = exp_q.pop_front();
            check("pulse_timeout", timeout, e.is_to);
            check("pulse_done", done, !e.is_to);
            check("inhibit_len", inh_len_last, INH);
            check("clk_oe_at_end", ps2_clk_oe, 1'b0);
            check("dat_oe_at_end", ps2_dat_oe, 1'b0);
            check("busy_at_end", busy, 1'b0);
            if (e.is_to) begin
               check("timeout_delay", cyc - tx_entry_cyc, TO);
            end else begin
               check("frame_bits", cap_bits, e.bits);
               check("ack_err", ack_err, e.ack_err);
            end
         end
      end
   end

   task automatic do_send(input logic [7:0] d);
      data = d;
      send = 1'b1;
      @(negedge clock);
      send = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("idle_reached", busy, 1'b0);
   endtask

   // Device model: clocks 11 falling edges, captures the host's line levels,
   // optionally pulls ACK low, and can assert reset after a chosen edge.
   task automatic dev_frame(input bit do_ack, input int abort_at);
      int n = 0;
      while (ps2_clk_oe && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("clk_released", ps2_clk_oe, 1'b0);
      cap_bits = '0;
      for (int i = 1; i <= 11; i++) begin
         repeat (H) @(negedge clock);
         if (i == 1) cap_bits[0] = ps2_dat_in;
         if (i == 11 && do_ack) begin
            dev_dat = 1'b0;
            @(negedge clock);
         end
         dev_clk = 1'b0;
         if (i == abort_at) begin
            repeat (4) @(negedge clock);
            check("dat_oe_before_reset", ps2_dat_oe, 1'b1);
            reset = 1'b1;
            #1;
            check("reset_clk_oe", ps2_clk_oe, 1'b0);
            check("reset_dat_oe", ps2_dat_oe, 1'b0);
            check("reset_busy", busy, 1'b0);
            check("reset_done", done, 1'b0);
            check("reset_timeout", timeout, 1'b0);
            @(negedge clock);
            @(negedge clock);
            reset   = 1'b0;
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            return;
         end
         repeat (H) @(negedge clock);
         if (i <= 10) cap_bits[i] = ps2_dat_in;
         dev_clk = 1'b1;
      end
      repeat (H) @(negedge clock);
      dev_dat = 1'b1;
   endtask

   initial begin
      reset   = 1'b1;
      send    = 1'b0;
      data    = 8'h00;
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_clk_oe", ps2_clk_oe, 1'b0);
      check("rst_dat_oe", ps2_dat_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ack_err", ack_err, 1'b0);
      check("rst_timeout", timeout, 1'b0);

      // A send while reset is held must be ignored.
      do_send(8'h3C);
      repeat (20) @(negedge clock);
      check("rst_send_busy", busy, 1'b0);
      check("rst_send_clk_oe", ps2_clk_oe, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("idle_busy", busy, 1'b0);

      // 0xED, parity 1, ACKed; a 0x55 send during the transfer is ignored.
      push_exp(1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0);
      do_send(8'hED);
      check("busy_after_accept", busy, 1'b1);
      check("clk_oe_after_accept", ps2_clk_oe, 1'b1);
      repeat (2) @(negedge clock);
      do_send(8'h55);
      dev_frame(1'b1, 0);
      wait_idle();

      // 0x07, parity 0, device does not ACK.
      push_exp(1'b0, {1'b1, 1'b0, 8'h07, 1'b0}, 1'b1);
      do_send(8'h07);
      dev_frame(1'b0, 0);
      wait_idle();
      repeat (3) @(negedge clock);
      check("ack_err_held", ack_err, 1'b1);

      // Device never clocks: timeout after TO cycles in TX.
      push_exp(1'b1, 11'h000, 1'b0);
      do_send(8'hA5);
      check("ack_err_cleared", ack_err, 1'b0);
      wait_idle();

      // Reset after falling edge 5 of an 0xED frame: no pulse of any kind.
      do_send(8'hED);
      dev_frame(1'b1, 5);
      repeat (10) @(negedge clock);
      check("post_abort_busy", busy, 1'b0);

      // Recovery frame 0x00, parity 1, ACKed.
      push_exp(1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);
      do_send(8'h00);
      dev_frame(1'b1, 0);
      wait_idle();

      repeat (5) @(negedge clock);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got no end of test, expected finish");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low hold before start (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum cycles from clock release to completion (15 ms at 50 MHz).
REQ-003 SHALL have port clock  input  1  system clock, 50 MHz; one clock domain, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port send  input  1  single-cycle request to transmit data.
REQ-006 SHALL have port data  input  8  byte to transmit, sampled when send is accepted.
REQ-007 SHALL have port ps2_clk_in  input  1  raw PS2_CLK pin level, asynchronous.
REQ-008 SHALL have port ps2_dat_in  input  1  raw PS2_DAT pin level, asynchronous.
REQ-009 SHALL have port ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release; the top level maps it to 0 or high-Z.
REQ-010 SHALL have port ps2_dat_oe  output  1  1 = drive PS2_DAT low, 0 = release.
REQ-011 SHALL have port busy  output  1  high from send acceptance until return to IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-013 SHALL have port ack_err  output  1  valid with done; 1 = device did not acknowledge.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse on an aborted transfer.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_dat_in through two-flop synchronisers; a falling edge is sync_clk=0 with the previous sync_clk=1.
REQ-016 SHALL implement states IDLE, INHIBIT, TX, ACK, WAIT_IDLE.
REQ-017 IDLE: outputs released, busy=0; a send in this state latches data and parity = XNOR-reduce(data) (odd parity), then enters INHIBIT on the next cycle with busy=1.
REQ-018 SHALL ignore send in any state other than IDLE; the latched byte is unchanged.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_dat_oe=1 (start bit) from the final INHIBIT cycle onward.
REQ-020 After INHIBIT, SHALL enter TX with ps2_clk_oe=0, ps2_dat_oe=1, and start the timeout counter at 0.
REQ-021 TX, falling edges 1..8: ps2_dat_oe = NOT data[n-1] (LSB first).
REQ-022 TX, falling edge 9: ps2_dat_oe = NOT parity.
REQ-023 TX, falling edge 10: ps2_dat_oe=0 (stop bit); the block then enters ACK.
REQ-024 ACK: on falling edge 11, SHALL sample sync_dat; ack_err is latched as sync_dat (1 = no ACK); the block then enters WAIT_IDLE.
REQ-025 WAIT_IDLE: SHALL wait until sync_clk=1 and sync_dat=1, then pulse done for one cycle, hold ack_err until the next acceptance, and return to IDLE (busy=0 on that same cycle).
REQ-026 Timeout counter: increments every cycle in TX, ACK and WAIT_IDLE.
REQ-027 When the counter reaches TIMEOUT_CYCLES, the block SHALL release both lines, pulse timeout, not pulse done, and return to IDLE.
REQ-028 When a falling edge and the timeout limit coincide, the timeout SHALL take priority.
REQ-029 SHALL never drive ps2_dat_oe and change bits except on a detected falling edge while in TX.
REQ-030 SHALL size the bit counter to 4 bits and the timeout counter to $clog2(TIMEOUT_CYCLES+1); counters SHALL not wrap.
REQ-031 SHALL register all outputs; no combinational path from ps2_*_in to any output.

Reset
REQ-032 Reset SHALL act asynchronously: state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, ack_err=0, timeout=0; all counters and synchronisers cleared (synchronisers to 1).
REQ-033 Reset asserted mid-transfer SHALL release both lines in the same cycle, with no done or timeout pulse.

Verification
REQ-034 Reset with lines idle high -> all outputs 0; send with reset held -> no activity.
REQ-035 INHIBIT_CYCLES=16, send data=0xED, device model clocks 11 edges and drives ACK low -> clk_oe high for 16 cycles; dat_oe bits (inverted) = start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once, ack_err=0.
REQ-036 Send 0x07, device does not ACK -> parity bit 0, done pulse with ack_err=1, busy drops the same cycle.
REQ-037 TIMEOUT_CYCLES=200, device never clocks -> timeout pulse exactly 200 cycles after TX entry, both oe=0, no done.
REQ-038 Send 0x55 while busy on 0xED -> 0xED frame unchanged; reset asserted at falling edge 5 -> oe outputs 0 immediately, busy=0.
